// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq: iterative AES-128/192/256 key expansion, one word per clock through one shared SubWord,
// with indexed round-key reads allowed as soon as each round's four words exist.
module aes_sbox (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction
    always_comb dout = {sb(din[31:24]), sb(din[23:16]), sb(din[15:8]), sb(din[7:0])};
endmodule

module aes_key_sched_seq #(
    parameter int Nk = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Nk*32-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             key_ready,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
    output logic [127:0]     rk_out,
    output logic             rk_rd_valid,
    output logic             rk_rd_err
);
    localparam int NR = Nk + 6;
    localparam int W = 4 * NR + 4;
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
    state_t state_q, state_d;
    logic [5:0] i_q, i_d;
    logic [2:0] k_q, k_d;
    logic [6:0] a_q, a_d;
    logic [7:0] rcon_q, rcon_d;
    logic done_q, done_d, valid_q, valid_d, err_q, err_d;
    logic [127:0] rk_q, rk_d;
    logic [31:0] w_q [W];
    logic [31:0] prev, sub_in, sub_out, t, new_w;
    logic [5:0] rd_base;
    logic expanding, last, rd_ok;

    aes_sbox u_sbox (.din(sub_in), .dout(sub_out));

    // the only combinational path: store -> mux -> sbox -> xor -> store
    always_comb begin
        expanding = state_q == EXPAND;
        prev = w_q[i_q - 6'd1];
        sub_in = (k_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        t = (k_q == 3'd0) ? sub_out ^ {rcon_q, 24'h0} : (Nk == 8 && k_q == 3'd4) ? sub_out : prev;
        new_w = w_q[i_q - 6'(Nk)] ^ t;
        last = expanding && i_q == 6'(W - 1);
        rd_base = {rk_rd_idx, 2'b00};
        rd_ok = rk_rd_en && rk_rd_idx <= 4'(NR) && ({1'b0, rd_base} + 7'd3 < a_q);
    end

    always_comb state_d = start ? EXPAND : last ? READY : state_q;

    // reads are judged against the availability count before this edge, even on a restart edge
    always_comb begin
        i_d = start ? 6'(Nk) : expanding ? i_q + 6'd1 : i_q;
        k_d = start ? 3'd0 : expanding ? ((k_q == 3'(Nk - 1)) ? 3'd0 : k_q + 3'd1) : k_q;
        a_d = start ? 7'(Nk) : expanding ? a_q + 7'd1 : a_q;
        rcon_d = start ? 8'h01 : (expanding && k_q == 3'd0) ? ({rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00)) : rcon_q;
        done_d = last && !start;
        valid_d = rd_ok;
        err_d = rk_rd_en && !rd_ok;
        rk_d = rd_ok ? {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]} : rk_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q <= 6'(Nk);
            k_q <= '0;
            a_q <= '0;
            rcon_q <= 8'h01;
            done_q <= 1'b0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
            rk_q <= '0;
        end else begin
            state_q <= state_d;
            i_q <= i_d;
            k_q <= k_d;
            a_q <= a_d;
            rcon_q <= rcon_d;
            done_q <= done_d;
            valid_q <= valid_d;
            err_q <= err_d;
            rk_q <= rk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (start)
            for (int j = 0; j < Nk; j++) w_q[j] <= key[32 * (Nk - 1 - j) +: 32];
        else if (expanding)
            w_q[i_q] <= new_w;
    end

    always_comb begin
        busy = state_q == EXPAND;
        key_ready = state_q == READY;
        done = done_q;
        rk_rd_valid = valid_q;
        rk_rd_err = err_q;
        rk_out = rk_q;
    end
endmodule

// File: tb/tb_aes_key_sched_seq.sv
// tb_aes_key_sched_seq: scoreboard bench for the key-schedule sequencer, one instance at Nk=4 and one at Nk=8,
// using FIPS-197 key-expansion vectors.
module tb_aes_key_sched_seq;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1_1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R10_2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K8_HI = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] K8_LO = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R14_8 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [4:0] B = 5'b10000, D = 5'b01000, R = 5'b00100, BDR = 5'b11100;

    typedef struct { logic err; logic [127:0] data; } rd_t;
    typedef struct { int c; int d; logic [4:0] f; logic [4:0] m; logic co; logic [127:0] o; } st_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst [2], start [2], rd_en [2];
    logic [3:0] idx [2];
    logic [127:0] key4;
    logic [255:0] key8;
    logic busy [2], done [2], kr [2], vld [2], err [2];
    logic [127:0] rko [2];

    rd_t rq0[$], rq1[$];
    int dq0[$], dq1[$];
    st_t sq[$];
    int errors = 0, checks = 0;
    bit fin = 1'b0;

    aes_key_sched_seq #(.Nk(4)) u4 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .key(key4), .busy(busy[0]), .done(done[0]),
        .key_ready(kr[0]), .rk_rd_en(rd_en[0]), .rk_rd_idx(idx[0]), .rk_out(rko[0]),
        .rk_rd_valid(vld[0]), .rk_rd_err(err[0])
    );
    aes_key_sched_seq #(.Nk(8)) u8 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .key(key8), .busy(busy[1]), .done(done[1]),
        .key_ready(kr[1]), .rk_rd_en(rd_en[1]), .rk_rd_idx(idx[1]), .rk_out(rko[1]),
        .rk_rd_valid(vld[1]), .rk_rd_err(err[1])
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic rd(input int d, input logic [3:0] i, input logic e, input logic [127:0] x);
        rd_en[d] = 1'b1;
        idx[d] = i;
        if (d == 0) rq0.push_back('{e, x});
        else rq1.push_back('{e, x});
        @(negedge clk);
        rd_en[d] = 1'b0;
    endtask

    task automatic st(input int c, input int d, input logic [4:0] f, input logic [4:0] m, input logic co, input logic [127:0] o);
        sq.push_back('{c, d, f, m, co, o});
    endtask

    // monitor: pops the scoreboard whenever a DUT presents a response
    always @(negedge clk) begin
        rd_t e;
        int ec;
        logic [4:0] fl;
        for (int d = 0; d < 2; d++) begin
            if (vld[d] === 1'b1 || err[d] === 1'b1) begin
                checks++;
                if ((d == 0 && rq0.size() == 0) || (d == 1 && rq1.size() == 0)) begin
                    errors++;
                    $display("FAIL rd_unexpected dut%0d cyc %0d: valid=%0b err=%0b, required no response", d, cyc, vld[d], err[d]);
                end else begin
                    if (d == 0) e = rq0.pop_front();
                    else e = rq1.pop_front();
                    if (vld[d] == e.err || err[d] != e.err || (!e.err && rko[d] != e.data)) begin
                        errors++;
                        $display("FAIL rd dut%0d cyc %0d: valid=%0b err=%0b out=%h, required err=%0b out=%h",
                                 d, cyc, vld[d], err[d], rko[d], e.err, e.data);
                    end
                end
            end
            if (done[d] === 1'b1) begin
                checks++;
                if ((d == 0 && dq0.size() == 0) || (d == 1 && dq1.size() == 0)) begin
                    errors++;
                    $display("FAIL done_unexpected dut%0d: done at cyc %0d, required none", d, cyc);
                end else begin
                    if (d == 0) ec = dq0.pop_front();
                    else ec = dq1.pop_front();
                    if (cyc != ec) begin
                        errors++;
                        $display("FAIL done_cycle dut%0d: done at cyc %0d, required cyc %0d", d, cyc, ec);
                    end
                end
            end
        end
        for (int j = sq.size() - 1; j >= 0; j--) begin
            if (sq[j].c == cyc) begin
                fl = {busy[sq[j].d], done[sq[j].d], kr[sq[j].d], vld[sq[j].d], err[sq[j].d]};
                checks++;
                if ((fl & sq[j].m) !== (sq[j].f & sq[j].m) || (sq[j].co && rko[sq[j].d] !== sq[j].o)) begin
                    errors++;
                    $display("FAIL status dut%0d cyc %0d: busy/done/ready/valid/err=%b out=%h, required %b (mask %b) out=%h",
                             sq[j].d, cyc, fl, rko[sq[j].d], sq[j].f, sq[j].m, sq[j].o);
                end
                sq.delete(j);
            end
        end
        if (fin) begin
            checks++;
            if (rq0.size() + rq1.size() != 0) begin
                errors++;
                $display("FAIL rd_missing: pending=%0d, required 0", rq0.size() + rq1.size());
            end
            checks++;
            if (dq0.size() + dq1.size() != 0) begin
                errors++;
                $display("FAIL done_missing: pending=%0d, required 0", dq0.size() + dq1.size());
            end
            checks++;
            if (sq.size() != 0) begin
                errors++;
                $display("FAIL status_missing: pending=%0d, required 0", sq.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1);
    end

    initial begin
        int s;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            start[d] = 1'b0;
            rd_en[d] = 1'b0;
            idx[d] = '0;
        end
        key4 = '0;
        key8 = '0;
        step(2);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        st(cyc + 1, 0, 5'b0, 5'b11111, 1'b1, '0);
        st(cyc + 1, 1, 5'b0, 5'b11111, 1'b1, '0);
        step(1);
        rd(0, 0, 1'b1, '0);
        rd(1, 3, 1'b1, '0);
        // FIPS-197 AES-128 expansion with early and boundary reads
        key4 = K1;
        start[0] = 1'b1;
        s = cyc + 1;
        dq0.push_back(s + 40);
        step(1);
        start[0] = 1'b0;
        rd(0, 10, 1'b1, '0);
        st(s + 3, 0, B, BDR, 1'b0, '0);
        st(s + 39, 0, B, BDR, 1'b0, '0);
        st(s + 41, 0, R, BDR, 1'b0, '0);
        wait_cyc(s + 3);
        rd(0, 1, 1'b1, '0);
        rd(0, 1, 1'b0, R1_1);
        rd(0, 0, 1'b0, K1);
        wait_cyc(s + 42);
        rd(0, 10, 1'b0, R10_1);
        rd(0, 0, 1'b0, K1);
        rd(0, 11, 1'b1, '0);
        rd(0, 1, 1'b0, R1_1);
        // restart 20 cycles in with a concurrent read judged on the old expansion
        start[0] = 1'b1;
        s = cyc + 1;
        step(1);
        start[0] = 1'b0;
        wait_cyc(s + 19);
        key4 = K2;
        start[0] = 1'b1;
        dq0.push_back(s + 60);
        st(s + 40, 0, B, BDR, 1'b0, '0);
        st(s + 59, 0, B, BDR, 1'b0, '0);
        st(s + 61, 0, R, BDR, 1'b0, '0);
        rd(0, 1, 1'b0, R1_1);
        start[0] = 1'b0;
        rd(0, 2, 1'b1, '0);
        rd(0, 0, 1'b0, K2);
        wait_cyc(s + 62);
        key4 = '1;
        rd(0, 10, 1'b0, R10_2);
        rd(0, 0, 1'b0, K2);
        rd(0, 11, 1'b1, '0);
        // asynchronous reset mid-expansion, then a clean rerun
        key4 = K1;
        start[0] = 1'b1;
        s = cyc + 1;
        step(1);
        start[0] = 1'b0;
        wait_cyc(s + 9);
        st(s + 10, 0, 5'b0, 5'b11111, 1'b1, '0);
        @(posedge clk);
        #2 rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        rd(0, 0, 1'b1, '0);
        start[0] = 1'b1;
        s = cyc + 1;
        dq0.push_back(s + 40);
        st(s + 20, 0, B, BDR, 1'b0, '0);
        step(1);
        start[0] = 1'b0;
        wait_cyc(s + 42);
        rd(0, 10, 1'b0, R10_1);
        rd(0, 1, 1'b0, R1_1);
        // FIPS-197 AES-256 expansion: rounds 0 and 1 exist from the start edge
        key8 = {K8_HI, K8_LO};
        start[1] = 1'b1;
        s = cyc + 1;
        dq1.push_back(s + 52);
        st(s + 51, 1, B, BDR, 1'b0, '0);
        st(s + 53, 1, R, BDR, 1'b0, '0);
        step(1);
        start[1] = 1'b0;
        rd(1, 1, 1'b0, K8_LO);
        rd(1, 2, 1'b1, '0);
        wait_cyc(s + 54);
        rd(1, 14, 1'b0, R14_8);
        rd(1, 15, 1'b1, '0);
        rd(1, 0, 1'b0, K8_HI);
        step(3);
        fin = 1'b1;
        step(3);
    end
endmodule

// File: doc/aes_key_sched_seq.md
# aes_key_sched_seq

Iterative AES key-schedule sequencer. It expands a 128/192/256-bit cipher key into 4*Nr+4 round-key words, one word per clock, through a single shared `aes_sbox` instance, and stores them in an internal word store. It sits between the key-load interface and the round datapath. The round datapath fetches each 128-bit round key by index as soon as that key has been generated, so encryption can begin before expansion finishes. It is the area-lean, sequenced alternative to the fully unrolled combinational expansion.

## Interface
- `Nk`, default 4, key length in 32-bit words; legal values 4, 6, 8. Derived values: Nr = Nk+6, W = 4*Nr+4 words (44/52/60).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: load `key` and begin expansion; sampled every cycle.
- `key` input Nk*32: cipher key; word 0 in the MSBs.
- `busy` output 1: expansion in progress.
- `done` output 1: one-cycle pulse when the last word is written.
- `key_ready` output 1: level; all W words are valid.
- `rk_rd_en` input 1: round-key read request.
- `rk_rd_idx` input 4: round index, 0..Nr.
- `rk_out` output 128: {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits 127:96.
- `rk_rd_valid` output 1: one-cycle pulse; `rk_out` is valid.
- `rk_rd_err` output 1: one-cycle pulse; the read was refused.

## Operation
- States:
  - IDLE: reset state.
  - EXPAND.
  - READY.
- `start` is accepted in any state, including mid-EXPAND and READY, where it aborts and restarts.
  - On the accepting edge: words 0..Nk-1 are written from `key`, i = Nk, rcon = 8'h01, k = 0 (k = i mod Nk, kept as a counter with no divider), availability count a = Nk, and the state moves to EXPAND.
- EXPAND: each edge writes w[i] = w[i-Nk] ^ t, then i++, a++, k wraps at Nk.
  - When k==0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}. After use, rcon = xtime(rcon), i.e. shift left, XOR 8'h1b if bit 7 was set.
  - When Nk==8 and k==4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
  - RotWord is a left byte rotate. The single `aes_sbox` input is muxed between RotWord(w[i-1]) and w[i-1].
  - The edge that writes w[W-1] moves the state to READY and registers `done`=1 for the next cycle.
- READY: holds until `start` or reset. `key` changes are ignored unless `start` is asserted.
- Reads:
  - Sampled on an edge with `rk_rd_en`=1.
  - If rk_rd_idx <= Nr and 4*rk_rd_idx+3 < a (counting words of the current expansion only), `rk_out` is registered and `rk_rd_valid`=1. Otherwise `rk_rd_err`=1 and `rk_out` holds its previous value.
  - In IDLE, a = 0, so every read errors.
- Read and start on the same edge: the read is evaluated against the pre-start a.
  - A restart invalidates all rounds except round 0 (and round 1 when Nk = 8).
  - Any round with 4r+3 < Nk becomes available on the start edge itself.
- Reads of a word being written on the same edge: not available; w[i] counts only after its write edge.

## Timing
- Reset values:
  - State IDLE; `busy`, `done`, `key_ready`, `rk_rd_valid`, `rk_rd_err` = 0.
  - `rk_out` = 0, a = 0, rcon = 8'h01.
  - Word store contents are not reset.
- `busy` = 1 exactly in EXPAND. `key_ready` = 1 exactly in READY.
- Expansion latency from the start edge to the last-word edge is W-Nk edges (40/46/52). `done` is high in the cycle after that edge.
- Read latency is 1 cycle. Back-to-back reads are allowed every cycle.
- Reset asserted mid-expansion returns to IDLE immediately. The next start runs a full expansion.
- All outputs are registered. The only combinational path is word store → mux → sbox → XOR → word store, one word per cycle.

## Test plan
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, start → `done` 40 cycles later. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → `done` 52 cycles later. Round 14 = fe4890d1e6188d0b046df344706c631e.
- Nk=4, read idx 10 one cycle after start → `rk_rd_err`. Read idx 1 at the edge after w[7] is written → `rk_rd_valid` with the round-1 value above.
- Read idx 11 in READY (Nk=4) → `rk_rd_err`. Read in IDLE after reset → `rk_rd_err`.
- Restart with key 000102030405060708090a0b0c0d0e0f 20 cycles into an expansion:
  - `busy` stays high and `done` comes 40 cycles after the restart.
  - Round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - Round 2 read immediately after the restart errors.
- `rst` pulsed mid-EXPAND → all outputs 0 asynchronously. A subsequent start gives correct keys.
